branch_resolve_unit: RTL and testbench

Back-end partner of the branch target buffer. Records every fetched PC with the target the BTB predicted for it, checks each prediction against the real outcome when the branch resolves in execute, and emits BTB write commands plus a pipeline redirect/flush on mispredict. Sits between the fetch stage (BTB lookup side) and the execute stage (branch/jump resolution).

---
 rtl/branch_resolve_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks in-flight fetch predictions, checks them at resolve time,
// and issues BTB write commands plus redirect/flush on a mispredict.
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int LOWER        = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              fetch_valid,
    input  logic [63:0]       fetch_pc,
    input  logic [63:0]       fetch_pred_pc,
    output logic              fetch_ready,
    input  logic              resolve_valid,
    input  logic              resolve_is_branch,
    input  logic              resolve_taken,
    input  logic              resolve_is_jump,
    input  logic [63:0]       resolve_target,
    output logic              btb_we,
    output logic [LOWER-1:0]  btb_index,
    output logic [63-LOWER:0] btb_tag,
    output logic [63:0]       btb_target,
    output logic              redirect_valid,
    output logic [63:0]       redirect_pc,
    output logic              flush,
    output logic [31:0]       mispredict_count,
    output logic              err_underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_ONE     = FC_W'(1);

    logic [0:0]        state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [63:0]       pc_mem_q   [DEPTH];
    logic [63:0]       pred_mem_q [DEPTH];

    logic              btb_we_q, btb_we_d;
    logic [LOWER-1:0]  btb_index_q, btb_index_d;
    logic [63-LOWER:0] btb_tag_q, btb_tag_d;
    logic [63:0]       btb_target_q, btb_target_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [63:0]       redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic [31:0]       mispredict_count_q, mispredict_count_d;
    logic              err_underflow_q, err_underflow_d;

    logic              push_s;
    logic              pop_s;
    logic              mem_we_s;
    logic              taken_s;
    logic              mispredict_s;
    logic              upd_set_s;
    logic              upd_clear_s;
    logic [63:0]       head_pc_s;
    logic [63:0]       head_pred_s;
    logic [63:0]       actual_next_s;
    logic [63:0]       predicted_next_s;

    assign fetch_ready = (state_q == ST_RUN) && (count_q < DEPTH_C);

    // Resolve-side decode: head entry, next-PC comparison and BTB update class.
    always_comb begin
        head_pc_s        = pc_mem_q[rd_ptr_q];
        head_pred_s      = pred_mem_q[rd_ptr_q];
        push_s           = fetch_valid & fetch_ready;
        pop_s            = (state_q == ST_RUN) & resolve_valid & (count_q != {CNT_W{1'b0}});
        taken_s          = resolve_is_jump | (resolve_is_branch & resolve_taken);
        actual_next_s    = taken_s ? resolve_target : (head_pc_s + 64'd4);
        predicted_next_s = (head_pred_s != 64'd0) ? head_pred_s : (head_pc_s + 64'd4);
        mispredict_s     = pop_s & (actual_next_s != predicted_next_s);
        upd_set_s        = 1'b0;
        upd_clear_s      = 1'b0;
        if (taken_s) begin
            upd_set_s = (head_pred_s != resolve_target);
        end else if (resolve_is_branch) begin
            upd_clear_s = (head_pred_s != 64'd0);
        end else begin
            upd_set_s   = 1'b0;
            upd_clear_s = 1'b0;
        end
        // A mispredict squashes the whole FIFO, including a same-cycle push.
        mem_we_s = push_s & ~mispredict_s;
    end

    // FIFO pointer/occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (mispredict_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // RUN/FLUSH control with the flush down-counter.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (mispredict_s) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == {FC_W{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - FC_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = {FC_W{1'b0}};
            end
        endcase
    end

    // Registered BTB command, redirect, status and counters.
    always_comb begin
        btb_we_d           = pop_s & (upd_set_s | upd_clear_s);
        btb_index_d        = btb_index_q;
        btb_tag_d          = btb_tag_q;
        btb_target_d       = btb_target_q;
        redirect_valid_d   = mispredict_s;
        redirect_pc_d      = redirect_pc_q;
        flush_d            = (state_d == ST_FLUSH);
        mispredict_count_d = mispredict_count_q;
        err_underflow_d    = err_underflow_q;
        if (btb_we_d) begin
            btb_index_d  = head_pc_s[LOWER-1:0];
            btb_tag_d    = head_pc_s[63:LOWER];
            btb_target_d = upd_set_s ? resolve_target : 64'd0;
        end else begin
            btb_target_d = btb_target_q;
        end
        if (mispredict_s) begin
            redirect_pc_d = actual_next_s;
            if (mispredict_count_q != 32'hFFFF_FFFF) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end else begin
                mispredict_count_d = mispredict_count_q;
            end
        end else begin
            redirect_pc_d = redirect_pc_q;
        end
        if ((state_q == ST_RUN) && resolve_valid && (count_q == {CNT_W{1'b0}})) begin
            err_underflow_d = 1'b1;
        end else begin
            err_underflow_d = err_underflow_q;
        end
    end

    // State flops.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q            <= ST_RUN;
            fcnt_q             <= {FC_W{1'b0}};
            wr_ptr_q           <= {PTR_W{1'b0}};
            rd_ptr_q           <= {PTR_W{1'b0}};
            count_q            <= {CNT_W{1'b0}};
            btb_we_q           <= 1'b0;
            btb_index_q        <= {LOWER{1'b0}};
            btb_tag_q          <= {(64-LOWER){1'b0}};
            btb_target_q       <= 64'd0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= 64'd0;
            flush_q            <= 1'b0;
            mispredict_count_q <= 32'd0;
            err_underflow_q    <= 1'b0;
        end else begin
            state_q            <= state_d;
            fcnt_q             <= fcnt_d;
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            btb_we_q           <= btb_we_d;
            btb_index_q        <= btb_index_d;
            btb_tag_q          <= btb_tag_d;
            btb_target_q       <= btb_target_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            flush_q            <= flush_d;
            mispredict_count_q <= mispredict_count_d;
            err_underflow_q    <= err_underflow_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= 64'd0;
                pred_mem_q[i] <= 64'd0;
            end
        end else if (mem_we_s) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc;
            pred_mem_q[wr_ptr_q] <= fetch_pred_pc;
        end
    end

    assign btb_we           = btb_we_q;
    assign btb_index        = btb_index_q;
    assign btb_tag          = btb_tag_q;
    assign btb_target       = btb_target_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush            = flush_q;
    assign mispredict_count = mispredict_count_q;
    assign err_underflow    = err_underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue-based reference model predicts
// BTB writes/redirects and per-cycle status; a negedge monitor compares DUT output events.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int LOWER = 5;
    localparam int FC    = 2;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              fetch_valid;
    logic [63:0]       fetch_pc;
    logic [63:0]       fetch_pred_pc;
    logic              fetch_ready;
    logic              resolve_valid;
    logic              resolve_is_branch;
    logic              resolve_taken;
    logic              resolve_is_jump;
    logic [63:0]       resolve_target;
    logic              btb_we;
    logic [LOWER-1:0]  btb_index;
    logic [63-LOWER:0] btb_tag;
    logic [63:0]       btb_target;
    logic              redirect_valid;
    logic [63:0]       redirect_pc;
    logic              flush;
    logic [31:0]       mispredict_count;
    logic              err_underflow;

    branch_resolve_unit #(.DEPTH(DEPTH), .LOWER(LOWER), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .arst_n(arst_n),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred_pc(fetch_pred_pc),
        .fetch_ready(fetch_ready),
        .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
        .resolve_taken(resolve_taken), .resolve_is_jump(resolve_is_jump),
        .resolve_target(resolve_target),
        .btb_we(btb_we), .btb_index(btb_index), .btb_tag(btb_tag), .btb_target(btb_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .mispredict_count(mispredict_count), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pred;
    } ent_t;

    typedef struct {
        logic        we;
        logic [63:0] idx;
        logic [63:0] tag;
        logic [63:0] tgt;
        logic        rd;
        logic [63:0] rpc;
    } ev_t;

    ent_t        mq[$];
    ev_t         exp_q[$];
    bit          m_flush;
    int          m_left;
    logic [31:0] m_cnt;
    bit          m_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output-event monitor: every BTB write / redirect must match the next expected event.
    always @(negedge clk) begin
        if (arst_n && (btb_we || redirect_valid)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {62'd0, btb_we, redirect_valid}, 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("btb_we", 64'(btb_we), 64'(e.we));
                chk("redirect_valid", 64'(redirect_valid), 64'(e.rd));
                if (e.we) begin
                    chk("btb_index", 64'(btb_index), e.idx);
                    chk("btb_tag", 64'(btb_tag), e.tag);
                    chk("btb_target", btb_target, e.tgt);
                end
                if (e.rd) chk("redirect_pc", redirect_pc, e.rpc);
            end
        end
    end

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_flush = 1'b0;
        m_left  = 0;
        m_cnt   = 32'd0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit fv, input logic [63:0] fpc, input logic [63:0] fpred,
                              input bit rv, input bit br, input bit tk, input bit j,
                              input logic [63:0] tgt);
        bit          ready;
        bit          mis;
        bit          taken;
        ent_t        h;
        ent_t        n;
        ev_t         e;
        logic [63:0] actual;
        logic [63:0] predicted;
        ready = !m_flush && (mq.size() < DEPTH);
        mis   = 1'b0;
        if (m_flush) begin
            m_left--;
            if (m_left == 0) m_flush = 1'b0;
        end else begin
            if (rv) begin
                if (mq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    h         = mq.pop_front();
                    taken     = j || (br && tk);
                    actual    = taken ? tgt : h.pc + 64'd4;
                    predicted = (h.pred != 64'd0) ? h.pred : h.pc + 64'd4;
                    mis       = (actual != predicted);
                    e.we  = 1'b0;
                    e.tgt = 64'd0;
                    if (taken && h.pred != tgt) begin
                        e.we  = 1'b1;
                        e.tgt = tgt;
                    end else if (!taken && br && h.pred != 64'd0) begin
                        e.we  = 1'b1;
                        e.tgt = 64'd0;
                    end
                    e.idx = h.pc % 64'(1 << LOWER);
                    e.tag = h.pc >> LOWER;
                    e.rd  = mis;
                    e.rpc = actual;
                    if (e.we || e.rd) exp_q.push_back(e);
                    if (mis) begin
                        mq.delete();
                        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                        m_flush = 1'b1;
                        m_left  = FC;
                    end
                end
            end
            if (fv && ready && !mis) begin
                n.pc   = fpc;
                n.pred = fpred;
                mq.push_back(n);
            end
        end
    endtask

    task automatic check_status();
        chk("fetch_ready", 64'(fetch_ready), 64'(!m_flush && (mq.size() < DEPTH)));
        chk("flush", 64'(flush), 64'(m_flush));
        chk("mispredict_count", 64'(mispredict_count), 64'(m_cnt));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
        chk("pending_events", 64'(exp_q.size() > 1), 64'd0);
    endtask

    task automatic cycle(input bit fv, input logic [63:0] fpc, input logic [63:0] fpred,
                         input bit rv, input bit br, input bit tk, input bit j,
                         input logic [63:0] tgt);
        @(negedge clk);
        check_status();
        fetch_valid       = fv;
        fetch_pc          = fpc;
        fetch_pred_pc     = fpred;
        resolve_valid     = rv;
        resolve_is_branch = br;
        resolve_taken     = tk;
        resolve_is_jump   = j;
        resolve_target    = tgt;
        model_step(fv, fpc, fpred, rv, br, tk, j, tgt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fetch_ready"}, 64'(fetch_ready), 64'd1);
        chk({tag, "_btb_we"}, 64'(btb_we), 64'd0);
        chk({tag, "_btb_index"}, 64'(btb_index), 64'd0);
        chk({tag, "_btb_tag"}, 64'(btb_tag), 64'd0);
        chk({tag, "_btb_target"}, btb_target, 64'd0);
        chk({tag, "_redirect_valid"}, 64'(redirect_valid), 64'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 64'd0);
        chk({tag, "_flush"}, 64'(flush), 64'd0);
        chk({tag, "_mispredict_count"}, 64'(mispredict_count), 64'd0);
        chk({tag, "_err_underflow"}, 64'(err_underflow), 64'd0);
    endtask

    function automatic logic [63:0] rnd_pc();
        if ($urandom_range(0, 3) == 0) return {$urandom, $urandom} & ~64'h3;
        return 64'($urandom_range(0, 1023)) * 64'd4;
    endfunction

    function automatic logic [63:0] rnd_tgt();
        return 64'($urandom_range(1, 15)) * 64'd16;
    endfunction

    initial begin
        logic [63:0] fpc;
        logic [63:0] fpred;
        logic [63:0] tgt;
        bit          fv;
        bit          rv;
        bit          br;
        bit          tk;
        bit          j;

        arst_n = 1'b0;
        fetch_valid = 1'b0; fetch_pc = 64'd0; fetch_pred_pc = 64'd0;
        resolve_valid = 1'b0; resolve_is_branch = 1'b0; resolve_taken = 1'b0;
        resolve_is_jump = 1'b0; resolve_target = 64'd0;
        model_reset();
        #12;
        check_reset_outputs("por");
        arst_n = 1'b1;

        // Correct prediction: no write, no redirect.
        cycle(1'b1, 64'h100, 64'h200, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h200);
        idle(2);
        // Cold taken branch: write + redirect + flush.
        cycle(1'b1, 64'h104, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h40);
        idle(4);
        // False prediction on a not-taken branch.
        cycle(1'b1, 64'h120, 64'h300, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        idle(4);
        // Fill past capacity, then stream push+pop through pointer wrap.
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'h200 + 64'(i * 4), 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 64'h400 + 64'(i * 4), 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        // Flush squash with same-cycle push; resolves during FLUSH ignored.
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'h500 + 64'(i * 4), 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 64'h600, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h800);
        cycle(1'b1, 64'h604, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h900);
        cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h900);
        idle(2);
        // Underflow on empty FIFO.
        cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h10);
        idle(2);

        for (int k = 0; k < 800; k++) begin
            fv    = ($urandom_range(0, 99) < 70);
            fpc   = rnd_pc();
            fpred = ($urandom_range(0, 2) == 0) ? 64'd0 : rnd_tgt();
            rv    = ($urandom_range(0, 99) < 40);
            br    = $urandom_range(0, 1) == 1;
            tk    = $urandom_range(0, 1) == 1;
            j     = $urandom_range(0, 4) == 0;
            tgt   = rnd_tgt();
            if (mq.size() > 0 && mq[0].pred != 64'd0 && $urandom_range(0, 1) == 1) tgt = mq[0].pred;
            cycle(fv, fpc, fpred, rv, br, tk, j, tgt);
        end
        idle(4);

        // Asynchronous reset in the middle of FLUSH.
        cycle(1'b1, 64'h700, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h900);
        @(negedge clk);
        check_status();
        fetch_valid = 1'b0;
        resolve_valid = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("midflush");
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        idle(3);
        cycle(1'b1, 64'h104, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h40);
        idle(4);
        chk("events_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
